det3x3_seq_responder: RTL



---
 rtl/det_pkg.sv | 35 +++
 rtl/det_term_mul.sv | 23 ++
 rtl/det3x3_seq_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/det_pkg.sv
// Shared types and constants for the sequential 3x3 determinant server.
package det_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    // Sarrus term order; the accumulator visits them in this sequence.
    localparam logic [2:0] TERM_AEI = 3'd0;
    localparam logic [2:0] TERM_BFG = 3'd1;
    localparam logic [2:0] TERM_CDH = 3'd2;
    localparam logic [2:0] TERM_CEG = 3'd3;
    localparam logic [2:0] TERM_BDI = 3'd4;
    localparam logic [2:0] TERM_AFH = 3'd5;

    // Bit n set means term n is subtracted.
    localparam logic [5:0] TERM_NEG = 6'b111000;

    function automatic int unsigned acc_width(input int unsigned dw);
        return 3 * dw + 2;
    endfunction

    function automatic logic term_is_neg(input logic [2:0] idx);
        logic neg;
        neg = 1'b0;
        if (idx <= TERM_AFH)
            neg = TERM_NEG[idx];
        return neg;
    endfunction

endpackage

// File: rtl/det_term_mul.sv
// Combinational signed x*y*z, sign-extended to the full accumulator width.
module det_term_mul #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 26
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic signed [DATA_W-1:0] z,
    output logic signed [ACC_W-1:0]  p
);

    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] ye;
    logic signed [ACC_W-1:0] ze;

    assign xe = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    assign ye = {{(ACC_W-DATA_W){y[DATA_W-1]}}, y};
    assign ze = {{(ACC_W-DATA_W){z[DATA_W-1]}}, z};

    // The exact product fits ACC_W, so keeping the low bits loses nothing.
    assign p = xe * ye * ze;

endmodule

// File: rtl/det3x3_seq_responder.sv
// Sequential 3x3 signed determinant: one Sarrus term per cycle through a shared multiplier.
// Define DET_SATURATE_EN to clamp det_res on overflow instead of wrapping.
module det3x3_seq_responder
    import det_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = acc_width(DATA_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    input  logic signed [DATA_W-1:0] d,
    input  logic signed [DATA_W-1:0] e,
    input  logic signed [DATA_W-1:0] f,
    input  logic signed [DATA_W-1:0] g,
    input  logic signed [DATA_W-1:0] h,
    input  logic signed [DATA_W-1:0] i,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic signed [ACC_W-1:0]  det_full,
    output logic signed [DATA_W-1:0] det_res,
    output logic                     det_ovf
);

    localparam logic signed [ACC_W-1:0] NMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t state;
    state_t state_nxt;

    logic [2:0] idx;
    logic signed [DATA_W-1:0] la, lb, lc, ld, le, lf, lg, lh, li;
    logic signed [DATA_W-1:0] mx, my, mz;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     ovf_nxt;
    logic signed [DATA_W-1:0] res_nxt;

    always_comb begin
        mx = '0;
        my = '0;
        mz = '0;
        case (idx)
            TERM_AEI: begin mx = la; my = le; mz = li; end
            TERM_BFG: begin mx = lb; my = lf; mz = lg; end
            TERM_CDH: begin mx = lc; my = ld; mz = lh; end
            TERM_CEG: begin mx = lc; my = le; mz = lg; end
            TERM_BDI: begin mx = lb; my = ld; mz = li; end
            TERM_AFH: begin mx = la; my = lf; mz = lh; end
            default:  begin mx = '0; my = '0; mz = '0; end
        endcase
    end

    det_term_mul #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mul (
        .x(mx),
        .y(my),
        .z(mz),
        .p(term)
    );

    always_comb begin
        acc_nxt = term_is_neg(idx) ? (acc - term) : (acc + term);
        ovf_nxt = (acc_nxt > NMAX) || (acc_nxt < NMIN);
`ifdef DET_SATURATE_EN
        if (ovf_nxt)
            res_nxt = acc_nxt[ACC_W-1] ? NMIN[DATA_W-1:0] : NMAX[DATA_W-1:0];
        else
            res_nxt = acc_nxt[DATA_W-1:0];
`else
        res_nxt = acc_nxt[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = CALC;
            CALC:    if (idx == TERM_AFH) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is masked by reset because IDLE is also the reset state.
    always_comb begin
        req_ready = (state == IDLE) && !reset;
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            acc      <= '0;
            det_full <= '0;
            det_res  <= '0;
            det_ovf  <= 1'b0;
            la <= '0; lb <= '0; lc <= '0;
            ld <= '0; le <= '0; lf <= '0;
            lg <= '0; lh <= '0; li <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        la <= a; lb <= b; lc <= c;
                        ld <= d; le <= e; lf <= f;
                        lg <= g; lh <= h; li <= i;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    idx <= idx + 3'd1;
                    if (idx == TERM_AFH) begin
                        det_full <= acc_nxt;
                        det_res  <= res_nxt;
                        det_ovf  <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
